// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: instruction word, opcode/funct3 constants and
// the memory-stage FSM state type.
package riscv_pkg;

    typedef logic [31:0] instruction_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE           = 1'b0,
        REQ_WAIT_RDATA = 1'b1
    } memstate_t;

    function automatic logic [6:0] opcode_of(input instruction_t instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] funct3_of(input instruction_t instr);
        return instr[14:12];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for RV32I loads/stores: byte enables, replicated
// store data, load extraction/extension and misalignment detection.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_result_o,
    output logic        misaligned_o
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    always_comb begin
        byte_shift = rdata_i >> {addr_i, 3'b000};
        half_shift = rdata_i >> {addr_i[1], 4'b0000};
        lbyte      = byte_shift[7:0];
        lhalf      = half_shift[15:0];

        be_o          = '0;
        wdata_o       = store_data_i;
        load_result_o = '0;
        misaligned_o  = 1'b0;

        case (funct3_i)
            F3_B, F3_BU: begin
                be_o          = 4'b0001 << addr_i;
                wdata_o       = {4{store_data_i[7:0]}};
                load_result_o = (funct3_i == F3_B) ? {{24{lbyte[7]}}, lbyte}
                                                   : {24'h0, lbyte};
            end
            F3_H, F3_HU: begin
                misaligned_o  = addr_i[0];
                be_o          = addr_i[0] ? 4'b0000 : (4'b0011 << addr_i);
                wdata_o       = {2{store_data_i[15:0]}};
                load_result_o = (funct3_i == F3_H) ? {{16{lhalf[15]}}, lhalf}
                                                   : {16'h0, lhalf};
            end
            F3_W: begin
                misaligned_o  = (addr_i != 2'b00);
                be_o          = (addr_i != 2'b00) ? 4'b0000 : 4'b1111;
                load_result_o = rdata_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/memstage.sv
// RV32I memory stage: issues loads/stores over a req/gnt/rvalid port,
// passes other instructions through one register, stalls while busy.
module memstage
    import riscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  instruction_t instruction_i,
    input  logic [31:0]  data_i,
    input  logic [31:0]  store_data_i,
    output logic         stall_o,
    output logic         valid_o,
    output logic [31:0]  data_o,
    output instruction_t instruction_o,
    output logic         misaligned_o,
    output logic         dmem_req_o,
    output logic         dmem_we_o,
    output logic [3:0]   dmem_be_o,
    output logic [31:0]  dmem_addr_o,
    output logic [31:0]  dmem_wdata_o,
    input  logic         dmem_gnt_i,
    input  logic         dmem_rvalid_i,
    input  logic [31:0]  dmem_rdata_i
);

    memstate_t    state_q, state_d;
    logic         valid_q;
    logic [31:0]  data_q, data_d;
    instruction_t instr_q;
    logic         mis_q;

    logic         is_load, is_store, is_mem, mis_op, retire;
    logic [2:0]   funct3;
    logic [3:0]   be;
    logic [31:0]  wdata, load_result;
    logic         align_mis;

    assign funct3   = funct3_of(instruction_i);
    assign is_load  = (opcode_of(instruction_i) == OP_LOAD);
    assign is_store = (opcode_of(instruction_i) == OP_STORE);
    assign is_mem   = is_load | is_store;
    // Stores have no unsigned variants, so funct3[2] set is reserved for them.
    assign mis_op   = is_mem & (align_mis | (is_store & funct3[2]));

    lsu_align u_align (
        .funct3_i      (funct3),
        .addr_i        (data_i[1:0]),
        .store_data_i  (store_data_i),
        .rdata_i       (dmem_rdata_i),
        .be_o          (be),
        .wdata_o       (wdata),
        .load_result_o (load_result),
        .misaligned_o  (align_mis)
    );

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        dmem_req_o = 1'b0;
        if (valid_i) begin
            if (!is_mem || mis_op) begin
                retire = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        dmem_req_o = 1'b1;
                        if (dmem_gnt_i) begin
                            if (is_store) retire = 1'b1;
                            else          state_d = REQ_WAIT_RDATA;
                        end
                    end
                    REQ_WAIT_RDATA: begin
                        if (dmem_rvalid_i) begin
                            retire  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (mis_op || is_store) data_d = '0;
        else if (is_load)       data_d = load_result;
        else                    data_d = data_i;
    end

    assign stall_o      = valid_i & ~retire;
    assign dmem_we_o    = dmem_req_o & is_store;
    assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
    assign dmem_addr_o  = {data_i[31:2], 2'b00};
    assign dmem_wdata_o = wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            instr_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= retire;
            mis_q   <= retire & mis_op;
            if (retire) begin
                data_q  <= data_d;
                instr_q <= instruction_i;
            end
        end
    end

    assign valid_o       = valid_q;
    assign data_o        = data_q;
    assign instruction_o = instr_q;
    assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_memstage.sv
// Directed-vector bench for memstage with hand-computed expectations.
module tb_memstage;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i, valid_i;
    instruction_t instruction_i;
    logic [31:0]  data_i, store_data_i;
    logic         stall_o, valid_o, misaligned_o;
    logic [31:0]  data_o;
    instruction_t instruction_o;
    logic         dmem_req_o, dmem_we_o;
    logic [3:0]   dmem_be_o;
    logic [31:0]  dmem_addr_o, dmem_wdata_o;
    logic         dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]  dmem_rdata_i;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    memstage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .instruction_i (instruction_i),
        .data_i        (data_i),
        .store_data_i  (store_data_i),
        .stall_o       (stall_o),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .instruction_o (instruction_o),
        .misaligned_o  (misaligned_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instruction_t mk(input logic [6:0] op, input logic [2:0] f3);
        return {7'b0, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with immediate gnt and rvalid one cycle later.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        instruction_t ins;
        ins = mk(OP_LOAD, f3);
        valid_i = 1'b1; instruction_i = ins; data_i = addr; dmem_gnt_i = 1'b1;
        #1;
        chk({tag, " req"}, {31'b0, dmem_req_o}, 32'd1);
        chk({tag, " stall1"}, {31'b0, stall_o}, 32'd1);
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        chk({tag, " req_wait"}, {31'b0, dmem_req_o}, 32'd0);
        chk({tag, " stall2"}, {31'b0, stall_o}, 32'd1);
        chk({tag, " bubble"}, {31'b0, valid_o}, 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        #1;
        chk({tag, " stall_rel"}, {31'b0, stall_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1'b0; valid_i = 1'b0;
        chk({tag, " valid"}, {31'b0, valid_o}, 32'd1);
        chk({tag, " data"}, data_o, exp);
        chk({tag, " instr"}, instruction_o, ins);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; instruction_i = '0; data_i = '0; store_data_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        tick(); tick();
        chk("rst valid", {31'b0, valid_o}, 32'd0);
        chk("rst data", data_o, 32'd0);
        chk("rst instr", instruction_o, 32'd0);
        chk("rst mis", {31'b0, misaligned_o}, 32'd0);
        chk("rst req", {31'b0, dmem_req_o}, 32'd0);
        rst_i = 1'b0;

        // ALU pass-through
        valid_i = 1'b1; instruction_i = mk(7'b0110011, 3'b000); data_i = 32'h0000_1234;
        #1;
        chk("add stall", {31'b0, stall_o}, 32'd0);
        chk("add req", {31'b0, dmem_req_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("add valid", {31'b0, valid_o}, 32'd1);
        chk("add data", data_o, 32'h0000_1234);
        chk("add instr", instruction_o, mk(7'b0110011, 3'b000));
        tick();
        chk("bubble valid", {31'b0, valid_o}, 32'd0);
        chk("bubble hold", data_o, 32'h0000_1234);

        // LW: check the issued request shape before the full sequence
        valid_i = 1'b1; instruction_i = mk(OP_LOAD, F3_W); data_i = 32'h100;
        #1;
        chk("lw be", {28'b0, dmem_be_o}, 32'hF);
        chk("lw addr", dmem_addr_o, 32'h100);
        chk("lw we", {31'b0, dmem_we_o}, 32'd0);
        do_load("lw", F3_W, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb", F3_B, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu", F3_BU, 32'h103, 32'h80FF_0000, 32'h0000_0080);
        do_load("lh", F3_H, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF);
        do_load("lhu", F3_HU, 32'h102, 32'h80FF_0000, 32'h0000_80FF);
        do_load("lb0", F3_B, 32'h200, 32'h1234_5678, 32'h0000_0078);

        // SH with gnt delayed three cycles
        valid_i = 1'b1; instruction_i = mk(OP_STORE, F3_H); data_i = 32'h102;
        store_data_i = 32'h0000_ABCD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sh req", {31'b0, dmem_req_o}, 32'd1);
            chk("sh we", {31'b0, dmem_we_o}, 32'd1);
            chk("sh be", {28'b0, dmem_be_o}, 32'hC);
            chk("sh wdata", dmem_wdata_o, 32'hABCD_ABCD);
            chk("sh addr", dmem_addr_o, 32'h100);
            chk("sh stall", {31'b0, stall_o}, 32'd1);
            tick();
            chk("sh bubble", {31'b0, valid_o}, 32'd0);
        end
        dmem_gnt_i = 1'b1;
        #1;
        chk("sh stall_gnt", {31'b0, stall_o}, 32'd0);
        tick();
        dmem_gnt_i = 1'b0; valid_i = 1'b0;
        chk("sh valid", {31'b0, valid_o}, 32'd1);
        chk("sh data", data_o, 32'd0);

        // SB, immediate gnt
        valid_i = 1'b1; instruction_i = mk(OP_STORE, F3_B); data_i = 32'h101;
        store_data_i = 32'h1234_5678; dmem_gnt_i = 1'b1;
        #1;
        chk("sb be", {28'b0, dmem_be_o}, 32'h2);
        chk("sb wdata", dmem_wdata_o, 32'h7878_7878);
        chk("sb stall", {31'b0, stall_o}, 32'd0);
        tick();
        dmem_gnt_i = 1'b0; valid_i = 1'b0;
        chk("sb valid", {31'b0, valid_o}, 32'd1);

        // Misaligned LW
        valid_i = 1'b1; instruction_i = mk(OP_LOAD, F3_W); data_i = 32'h101;
        #1;
        chk("mis req", {31'b0, dmem_req_o}, 32'd0);
        chk("mis stall", {31'b0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("mis valid", {31'b0, valid_o}, 32'd1);
        chk("mis flag", {31'b0, misaligned_o}, 32'd1);
        chk("mis data", data_o, 32'd0);
        tick();
        chk("mis pulse", {31'b0, misaligned_o}, 32'd0);

        // Reserved store funct3, plus stray rvalid in IDLE
        valid_i = 1'b1; instruction_i = mk(OP_STORE, 3'b100); data_i = 32'h100;
        dmem_rvalid_i = 1'b1;
        #1;
        chk("rsv req", {31'b0, dmem_req_o}, 32'd0);
        tick();
        valid_i = 1'b0; dmem_rvalid_i = 1'b0;
        chk("rsv flag", {31'b0, misaligned_o}, 32'd1);

        // Reset while waiting for rdata
        valid_i = 1'b1; instruction_i = mk(OP_LOAD, F3_W); data_i = 32'h100; dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0; valid_i = 1'b0;
        chk("rstw valid", {31'b0, valid_o}, 32'd0);
        chk("rstw data", data_o, 32'd0);
        valid_i = 1'b1; instruction_i = mk(OP_LOAD, F3_W); data_i = 32'h100;
        #1;
        chk("rstw idle_req", {31'b0, dmem_req_o}, 32'd1);
        valid_i = 1'b1; instruction_i = mk(7'b0110011, 3'b000); data_i = 32'h55;
        #1;
        chk("rstw add_stall", {31'b0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("rstw add_valid", {31'b0, valid_o}, 32'd1);
        chk("rstw add_data", data_o, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
